digit_serial_comparator: RTL and testbench
==========================================

# digit_serial_comparator

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands DIGIT bits per clock, most-significant digit first. It terminates early on the first differing digit and reports equal/lesser/greater through a start/done handshake. It succeeds the fixed 4-bit combinational comparator in the arithmetic datapath, where wide operands must be compared without a long combinational compare chain.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; N = WIDTH/DIGIT digits.
- EARLY_EXIT, 1, 1: stop at the first mismatching digit; 0: always run N cycles (constant latency).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- a  in  WIDTH  operand A, sampled at the accepting edge.
- b  in  WIDTH  operand B, sampled at the accepting edge.
- is_signed  in  1  two's-complement compare when 1; present only with CMP_SIGNED_EN.
- ready  out  1  block idle, can accept start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse: results valid.
- equal, lesser, greater  out  1 each  result flags (A vs B); one-hot after completion.
- cycles  out  $clog2(N)+1  number of RUN cycles used by the last comparison.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. On start=1, latch a, b (and is_signed) into shift registers, clear the digit index, clear equal/lesser/greater/cycles to 0, and go to RUN.
  - RUN: busy=1. Compare the top DIGIT bits of both shift registers, then shift both left by DIGIT and increment cycles.
    - First mismatch: record lesser or greater and set the decided flag. With EARLY_EXIT=1, go to DONE.
    - Last digit (index N-1): if no mismatch was recorded, set equal=1. Go to DONE.
    - With EARLY_EXIT=0, later digits never override a decided result (MSB-first priority).
  - DONE: done=1 for exactly one cycle; ready=0; go to IDLE.
- Results and cycles hold from DONE until the next accepted start.
- start while busy, or in DONE, is ignored; no queuing.
- Operand changes after the accepting edge have no effect.

## Timing
- ready = (state==IDLE), combinational from state; it reads 1 while rst_n is low.
- busy = (state==RUN). done is registered state decode.
- Latency: start accepted at edge 0; RUN occupies cycles 1..k, with k = first mismatching digit index + 1 (EARLY_EXIT=1) or k = N; done is high in cycle k+1; ready returns in cycle k+2.
- Minimum start-to-start spacing: k+2 cycles.
- Reset values: state IDLE, busy=0, done=0, equal=lesser=greater=0, cycles=0, shift registers 0.
- Reset asserted mid-RUN or in DONE aborts immediately and asynchronously. No done pulse is produced and the flags read 000.

## Configuration
- CMP_SIGNED_EN defined: the is_signed port exists and is latched at start.
  - When is_signed=1, the MSB of each latched operand is inverted (offset-binary mapping) before the first digit compare, giving a two's-complement order.
  - When is_signed=0, the compare is unsigned.
- CMP_SIGNED_EN undefined: no is_signed port; the compare is always unsigned; no inversion logic.

## Structure
- Package cmp_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - result enum (CMP_EQ, CMP_LT, CMP_GT), used internally before decode to flags;
  - a function computing the cycles width from WIDTH and DIGIT.
- Sub-module cmp_digit: combinational DIGIT-bit compare producing eq/lt/gt. One instance is used per RUN cycle.
- Parameter check at elaboration: WIDTH % DIGIT == 0 and DIGIT >= 1, otherwise $fatal.

## Test plan
Defaults unless stated: WIDTH=16, DIGIT=4, EARLY_EXIT=1.
1. a=0x5000, b=0x2000 -> greater=1, cycles=1, done high in cycle 2 after the accepting edge.
2. a=0x1234, b=0x1234 -> equal=1, cycles=4, done in cycle 5.
3. a=0x12A0, b=0x12B0 -> lesser=1, cycles=3. With EARLY_EXIT=0: lesser=1, cycles=4.
4. CMP_SIGNED_EN, a=0xFFFF, b=0x0001: is_signed=1 -> lesser=1; is_signed=0 -> greater=1.
5. start pulsed during RUN and during the DONE cycle -> ignored, result unchanged. start in the following IDLE cycle -> accepted.
6. rst_n dropped in RUN cycle 2 of a=0x1230, b=0x1234 -> busy=0, flags 000, no done. After release, ready=1 and a new compare completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the digit-serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_e;

    // Width of the cycle counter: enough to hold N = width/digit itself.
    function automatic int cycles_width(input int width, input int digit);
        int n;
        n = (digit >= 1) ? (width / digit) : 1;
        if (n < 1) n = 1;
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// rtl/cmp_digit.sv - combinational DIGIT-bit unsigned compare
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o
);

    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/digit_serial_comparator.sv
// rtl/digit_serial_comparator.sv - MSB-first digit-serial comparator; CMP_SIGNED_EN adds is_signed
module digit_serial_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
`ifdef CMP_SIGNED_EN
    input  logic                                  is_signed,
`endif
    output logic                                  ready,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  equal,
    output logic                                  lesser,
    output logic                                  greater,
    output logic [cycles_width(WIDTH, DIGIT)-1:0] cycles
);

    localparam int N  = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW = cycles_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "digit_serial_comparator: WIDTH must be a positive multiple of DIGIT");
    end

    cmp_state_e       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    cycles_q;
    logic             decided_q;
    logic             equal_q;
    logic             lesser_q;
    logic             greater_q;

    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic             d_eq;
    logic             d_lt;
    logic             d_gt;
    cmp_res_e         digit_res;

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto offset binary, so the
    // unsigned digit compare then yields the signed order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    assign a_load = is_signed ? (a ^ MSB_MASK) : a;
    assign b_load = is_signed ? (b ^ MSB_MASK) : b;
`else
    assign a_load = a;
    assign b_load = b;
`endif

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .a_i  (a_sh_q[WIDTH-1 -: DIGIT]),
        .b_i  (b_sh_q[WIDTH-1 -: DIGIT]),
        .eq_o (d_eq),
        .lt_o (d_lt),
        .gt_o (d_gt)
    );

    // Encode the current top-digit comparison as a single result value.
    always_comb begin
        digit_res = CMP_EQ;
        if (!d_eq) begin
            if (d_lt)      digit_res = CMP_LT;
            else if (d_gt) digit_res = CMP_GT;
        end
    end

    // Control FSM plus operand shifters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            idx_q     <= '0;
            cycles_q  <= '0;
            decided_q <= 1'b0;
            equal_q   <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q    <= a_load;
                        b_sh_q    <= b_load;
                        idx_q     <= '0;
                        cycles_q  <= '0;
                        decided_q <= 1'b0;
                        equal_q   <= 1'b0;
                        lesser_q  <= 1'b0;
                        greater_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q << DIGIT;
                    b_sh_q   <= b_sh_q << DIGIT;
                    idx_q    <= idx_q + CW'(1);
                    cycles_q <= cycles_q + CW'(1);
                    // Only the most significant mismatch decides the result.
                    if (!decided_q && digit_res != CMP_EQ) begin
                        lesser_q  <= (digit_res == CMP_LT);
                        greater_q <= (digit_res == CMP_GT);
                        decided_q <= 1'b1;
                        if (EARLY_EXIT != 0) state_q <= DONE;
                    end
                    if (idx_q == LAST_IDX) begin
                        if (!decided_q && digit_res == CMP_EQ) equal_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign equal   = equal_q;
    assign lesser  = lesser_q;
    assign greater = greater_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// tb/tb_digit_serial_comparator.sv - scoreboard bench for early-exit and constant-latency builds
module tb_digit_serial_comparator;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int N  = W / D;
    localparam int CW = $clog2(N) + 1;

    typedef struct {
        logic eq;
        logic lt;
        logic gt;
        int   cyc;
        int   acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sgn;
    logic          ready0, busy0, done0, eq0, lt0, gt0;
    logic          ready1, busy1, done1, eq1, lt1, gt1;
    logic [CW-1:0] cyc0, cyc1;

    int   tests = 0;
    int   fails = 0;
    int   cycle_no = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   pd0 = 1'b0;
    bit   pd1 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    digit_serial_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .is_signed(sgn),
`endif
        .ready(ready0), .busy(busy0), .done(done0),
        .equal(eq0), .lesser(lt0), .greater(gt0), .cycles(cyc0)
    );

    digit_serial_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .is_signed(sgn),
`endif
        .ready(ready1), .busy(busy1), .done(done1),
        .equal(eq1), .lesser(lt1), .greater(gt1), .cycles(cyc1)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: ordering from plain integer arithmetic, latency from the
    // position of the most significant differing digit.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input bit sv, input bit early, input int acc);
        exp_t   e;
        longint ia, ib;
        int     first;
        bit     use_signed;
        use_signed = 1'b0;
`ifdef CMP_SIGNED_EN
        use_signed = sv;
`endif
        if (use_signed) begin
            ia = $signed(av);
            ib = $signed(bv);
        end else begin
            ia = av;
            ib = bv;
        end
        e.eq = (ia == ib);
        e.lt = (ia < ib);
        e.gt = (ia > ib);
        first = N;
        for (int d = 0; d < N; d++)
            if (first == N && av[(N-1-d)*D +: D] != bv[(N-1-d)*D +: D]) first = d;
        e.cyc = early ? ((first == N) ? N : first + 1) : N;
        e.acc = acc;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic feq, input logic flt,
                         input logic fgt, input int cy, input logic bz, input logic rd);
        check({tag, "_flags"}, {feq, flt, fgt}, {e.eq, e.lt, e.gt});
        check({tag, "_cycles"}, cy, e.cyc);
        check({tag, "_latency"}, cycle_no - e.acc, e.cyc);
        check({tag, "_busy_ready_in_done"}, {bz, rd}, 2'b00);
    endtask

    // Monitor for the early-exit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pd0) begin
                check("dut0_done_one_cycle", done0, 0);
                check("dut0_ready_after_done", ready0, 1);
            end
            if (done0) begin
                if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
                else score("dut0", q0.pop_front(), eq0, lt0, gt0, int'(cyc0), busy0, ready0);
            end
            pd0 = done0;
        end else begin
            pd0 = 1'b0;
        end
    end

    // Monitor for the constant-latency instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pd1) begin
                check("dut1_done_one_cycle", done1, 0);
                check("dut1_ready_after_done", ready1, 1);
            end
            if (done1) begin
                if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
                else score("dut1", q1.pop_front(), eq1, lt1, gt1, int'(cyc1), busy1, ready1);
            end
            pd1 = done1;
        end else begin
            pd1 = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sv);
        int t;
        t = 0;
        while (!(ready0 && ready1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("wait_ready_timeout", 0, 1);
        start = 1'b1;
        a     = av;
        b     = bv;
        sgn   = sv;
        q0.push_back(model(av, bv, sv, 1'b1, cycle_no + 1));
        q1.push_back(model(av, bv, sv, 1'b0, cycle_no + 1));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sgn   = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] av, bv;
        int           k, pos, t;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sgn   = 1'b0;
        @(negedge clk);
        check("rst_ready", {ready0, ready1}, 2'b11);
        check("rst_busy_done", {busy0, done0, busy1, done1}, 0);
        check("rst_flags", {eq0, lt0, gt0, eq1, lt1, gt1}, 0);
        check("rst_cycles", {cyc0, cyc1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h5000, 16'h2000, 1'b0);
        issue(16'h1234, 16'h1234, 1'b0);
        issue(16'h12A0, 16'h12B0, 1'b0);
`ifdef CMP_SIGNED_EN
        issue(16'hFFFF, 16'h0001, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0);
`endif

        // Starts during RUN and DONE must be ignored; the next IDLE start is taken.
        issue(16'h1234, 16'h1234, 1'b0);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_in_run", {busy0, busy1}, 2'b11);
        repeat (3) @(negedge clk);
        check("done_cycle_reached", {done0, done1}, 2'b11);
        start = 1'b1; a = 16'h0000; b = 16'hFFFF;
        @(negedge clk);
        issue(16'h00F0, 16'h0F00, 1'b0);

        // Asynchronous abort in the second RUN cycle.
        issue(16'h1230, 16'h1234, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {busy0, busy1}, 0);
        check("abort_flags", {eq0, lt0, gt0, eq1, lt1, gt1}, 0);
        check("abort_ready", {ready0, ready1}, 2'b11);
        check("abort_cycles", {cyc0, cyc1}, 0);
        q0.delete();
        q1.delete();
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", {done0, done1}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h1230, 16'h1234, 1'b0);

        // Random operands with a controlled first-mismatch position.
        repeat (150) begin
            av = W'($urandom);
            k  = $urandom_range(0, N + 1);
            if (k > N) begin
                bv = W'($urandom);
            end else begin
                bv = av;
                if (k < N) begin
                    pos = N - 1 - k;
                    bv[pos*D +: D] = bv[pos*D +: D] ^ D'($urandom_range(1, (1 << D) - 1));
                    for (int j = 0; j < pos; j++) bv[j*D +: D] = D'($urandom);
                end
            end
            issue(av, bv, 1'($urandom_range(0, 1)));
        end

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
